// File: rtl/conv_out_streamer_if.sv
// Word-stream port of the conv output streamer: valid/ready handshake plus last and bus index.
// The master drives the word; the slave returns out_ready.
interface conv_out_streamer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_W      = 6
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [IDX_W-1:0]      out_index;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    output out_index,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    input  out_index,
    output out_ready
  );
endinterface

// File: rtl/conv_out_streamer.sv
// Snapshots the conv layer's float16 result bus on start and streams it out one word per
// valid/ready beat, flagging the final word and any NaN emitted in the frame.
module conv_out_streamer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N_WORDS    = 64,
  parameter bit          REVERSE    = 1'b0,
  parameter int unsigned IDX_W      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [0:N_WORDS*DATA_WIDTH-1]     data_in,
  conv_out_streamer_if.master               strm,
  output logic                              busy,
  output logic                              done,
  output logic                              nan_seen
);

  localparam logic [IDX_W-1:0] FirstIdx = REVERSE ? IDX_W'(N_WORDS - 1) : '0;
  localparam logic [IDX_W-1:0] LastIdx  = REVERSE ? '0 : IDX_W'(N_WORDS - 1);

  typedef enum logic {StIdle, StStream} state_e;

  state_e                          state_q;
  logic [0:N_WORDS*DATA_WIDTH-1]   frame_q;
  logic [IDX_W-1:0]                next_idx;
  logic                            beat;
  logic                            word_nan;

  always_comb begin
    next_idx = REVERSE ? strm.out_index - IDX_W'(1) : strm.out_index + IDX_W'(1);
    beat     = strm.out_valid & strm.out_ready;
    // Half-precision NaN: all-ones exponent with a non-zero mantissa (infinity excluded).
    word_nan = (&strm.out_data[14:10]) & (|strm.out_data[9:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      frame_q        <= '0;
      strm.out_data  <= '0;
      strm.out_valid <= 1'b0;
      strm.out_last  <= 1'b0;
      strm.out_index <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      nan_seen       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            frame_q        <= data_in;
            // First word comes straight from the bus so it is valid the cycle after start.
            strm.out_data  <= data_in[FirstIdx*DATA_WIDTH +: DATA_WIDTH];
            strm.out_index <= FirstIdx;
            strm.out_valid <= 1'b1;
            strm.out_last  <= (FirstIdx == LastIdx);
            busy           <= 1'b1;
            nan_seen       <= 1'b0;
            state_q        <= StStream;
          end
        end
        StStream: begin
          if (beat) begin
            if (word_nan) begin
              nan_seen <= 1'b1;
            end
            if (strm.out_last) begin
              strm.out_valid <= 1'b0;
              strm.out_last  <= 1'b0;
              busy           <= 1'b0;
              done           <= 1'b1;
              state_q        <= StIdle;
            end else begin
              strm.out_data  <= frame_q[next_idx*DATA_WIDTH +: DATA_WIDTH];
              strm.out_index <= next_idx;
              strm.out_last  <= (next_idx == LastIdx);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_out_streamer.sv
// Directed bench for conv_out_streamer: forward and reversed instances share stimulus; a vector
// table covers full-rate and backpressured frames, hand sequences cover the multi-cycle corners.
module tb_conv_out_streamer;

  localparam int unsigned DW = 16;
  localparam int unsigned NW = 4;
  localparam int unsigned IW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              ready;
  logic [0:NW*DW-1]  data_in;
  logic              busy_f, done_f, nan_f;
  logic              busy_r, done_r, nan_r;

  always #5 clk = ~clk;

  conv_out_streamer_if #(.DATA_WIDTH(DW), .IDX_W(IW)) sf ();
  conv_out_streamer_if #(.DATA_WIDTH(DW), .IDX_W(IW)) sr ();

  assign sf.out_ready = ready;
  assign sr.out_ready = ready;

  conv_out_streamer #(.DATA_WIDTH(DW), .N_WORDS(NW), .REVERSE(1'b0), .IDX_W(IW)) dut_f (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .strm     (sf.master),
    .busy     (busy_f),
    .done     (done_f),
    .nan_seen (nan_f)
  );

  conv_out_streamer #(.DATA_WIDTH(DW), .N_WORDS(NW), .REVERSE(1'b1), .IDX_W(IW)) dut_r (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .strm     (sr.master),
    .busy     (busy_r),
    .done     (done_r),
    .nan_seen (nan_r)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int beats    = 0;

  typedef struct {
    logic        start;
    logic        ready;
    logic        v;
    logic [15:0] d;
    logic [1:0]  i;
    logic        l;
    logic        b;
    logic        dn;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(logic st, logic rd, logic v, logic [15:0] d, logic [1:0] i,
                              logic l, logic b, logic dn);
    vec_t r;
    r.start = st; r.ready = rd; r.v = v; r.d = d; r.i = i; r.l = l; r.b = b; r.dn = dn;
    return r;
  endfunction

  function automatic logic [0:NW*DW-1] pack(logic [15:0] w0, logic [15:0] w1,
                                            logic [15:0] w2, logic [15:0] w3);
    return {w0, w1, w2, w3};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply inputs for the next rising edge, then return at the following falling edge.
  task automatic step(input logic st, input logic rd);
    start = st;
    ready = rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [0:NW*DW-1] base;
  logic [15:0]      rexp [4];

  initial begin
    base    = pack(16'h3C00, 16'h4000, 16'h4200, 16'h4400);
    reset   = 1'b1;
    start   = 1'b0;
    ready   = 1'b0;
    data_in = base;
    rexp[0] = 16'h4400; rexp[1] = 16'h4200; rexp[2] = 16'h4000; rexp[3] = 16'h3C00;

    // Full-rate frame, then backpressure pattern 1,0,0,1,0,1,1.
    tab.push_back(mk(1, 1, 1, 16'h3C00, 0, 0, 1, 0));
    tab.push_back(mk(0, 1, 1, 16'h4000, 1, 0, 1, 0));
    tab.push_back(mk(0, 1, 1, 16'h4200, 2, 0, 1, 0));
    tab.push_back(mk(0, 1, 1, 16'h4400, 3, 1, 1, 0));
    tab.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 0, 1));
    tab.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 1, 16'h3C00, 0, 0, 1, 0));
    tab.push_back(mk(0, 1, 1, 16'h4000, 1, 0, 1, 0));
    tab.push_back(mk(0, 0, 1, 16'h4000, 1, 0, 1, 0));
    tab.push_back(mk(0, 0, 1, 16'h4000, 1, 0, 1, 0));
    tab.push_back(mk(0, 1, 1, 16'h4200, 2, 0, 1, 0));
    tab.push_back(mk(0, 0, 1, 16'h4200, 2, 0, 1, 0));
    tab.push_back(mk(0, 1, 1, 16'h4400, 3, 1, 1, 0));
    tab.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 0, 1));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0));

    repeat (2) @(negedge clk);
    check("reset valid", {31'd0, sf.out_valid}, 0);
    check("reset last", {31'd0, sf.out_last}, 0);
    check("reset busy", {31'd0, busy_f}, 0);
    check("reset done", {31'd0, done_f}, 0);
    check("reset nan", {31'd0, nan_f}, 0);
    check("reset data", {16'd0, sf.out_data}, 0);
    check("reset index", {30'd0, sf.out_index}, 0);
    check("reset rev valid", {31'd0, sr.out_valid}, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < tab.size(); k++) begin
      if (sf.out_valid && tab[k].ready) beats++;
      step(tab[k].start, tab[k].ready);
      check($sformatf("vec%0d valid", k), {31'd0, sf.out_valid}, {31'd0, tab[k].v});
      check($sformatf("vec%0d last", k), {31'd0, sf.out_last}, {31'd0, tab[k].l});
      check($sformatf("vec%0d busy", k), {31'd0, busy_f}, {31'd0, tab[k].b});
      check($sformatf("vec%0d done", k), {31'd0, done_f}, {31'd0, tab[k].dn});
      if (tab[k].v) begin
        check($sformatf("vec%0d data", k), {16'd0, sf.out_data}, {16'd0, tab[k].d});
        check($sformatf("vec%0d index", k), {30'd0, sf.out_index}, {30'd0, tab[k].i});
      end
    end
    check("table beats", beats, 8);

    // Reversed ordering.
    for (int k = 0; k < 4; k++) begin
      step(k == 0, 1'b1);
      check($sformatf("rev%0d data", k), {16'd0, sr.out_data}, {16'd0, rexp[k]});
      check($sformatf("rev%0d index", k), {30'd0, sr.out_index}, 32'(3 - k));
      check($sformatf("rev%0d last", k), {31'd0, sr.out_last}, {31'd0, k == 3});
    end
    step(1'b0, 1'b1);
    check("rev done", {31'd0, done_r}, 1);
    check("rev valid end", {31'd0, sr.out_valid}, 0);
    step(1'b0, 1'b0);

    // Snapshot isolation and start ignored mid-frame.
    step(1'b1, 1'b1);
    check("iso w0", {16'd0, sf.out_data}, 32'h3C00);
    data_in = pack(16'h7E00, 16'h7E00, 16'h7E00, 16'h7E00);
    step(1'b1, 1'b1);
    check("iso w1", {16'd0, sf.out_data}, 32'h4000);
    step(1'b0, 1'b1);
    check("iso w2", {16'd0, sf.out_data}, 32'h4200);
    check("iso no done", {31'd0, done_f}, 0);
    step(1'b0, 1'b1);
    check("iso w3", {16'd0, sf.out_data}, 32'h4400);
    step(1'b0, 1'b1);
    check("iso done", {31'd0, done_f}, 1);
    check("iso nan", {31'd0, nan_f}, 0);
    // Back-to-back start on the done cycle picks up the NaN bus.
    step(1'b1, 1'b1);
    check("nan w0", {16'd0, sf.out_data}, 32'h7E00);
    check("nan idx0", {30'd0, sf.out_index}, 0);
    check("nan clear", {31'd0, nan_f}, 0);
    check("b2b done low", {31'd0, done_f}, 0);
    step(1'b0, 1'b1);
    check("nan set", {31'd0, nan_f}, 1);
    repeat (3) step(1'b0, 1'b1);
    check("nan done", {31'd0, done_f}, 1);
    check("nan sticky", {31'd0, nan_f}, 1);
    data_in = pack(16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00);
    step(1'b1, 1'b1);
    check("inf clear", {31'd0, nan_f}, 0);
    repeat (4) step(1'b0, 1'b1);
    check("inf done", {31'd0, done_f}, 1);
    check("inf nan", {31'd0, nan_f}, 0);

    // Asynchronous reset mid-frame.
    data_in = pack(16'h7E00, 16'h4000, 16'h4200, 16'h4400);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("pre-rst index", {30'd0, sf.out_index}, 2);
    check("pre-rst nan", {31'd0, nan_f}, 1);
    #2 reset = 1'b1;
    #1;
    check("rst valid", {31'd0, sf.out_valid}, 0);
    check("rst busy", {31'd0, busy_f}, 0);
    check("rst done", {31'd0, done_f}, 0);
    check("rst nan", {31'd0, nan_f}, 0);
    check("rst index", {30'd0, sf.out_index}, 0);
    @(negedge clk);
    reset   = 1'b0;
    data_in = base;
    step(1'b1, 1'b1);
    check("restart valid", {31'd0, sf.out_valid}, 1);
    check("restart index", {30'd0, sf.out_index}, 0);
    check("restart data", {16'd0, sf.out_data}, 32'h3C00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
